// File: rtl/exhaustive_vec_checker.sv
// Exhaustive vector checker: walks every N_IN-bit input vector REPEAT times,
// holds each one for SETTLE cycles and compares the DUT output against the
// TRUTH table on the last cycle of the hold. Counts compares and failures.
module exhaustive_vec_checker #(
   parameter int                   N_IN   = 4,
   parameter int                   SETTLE = 5,
   parameter int                   REPEAT = 2,
   parameter logic [(2**N_IN)-1:0] TRUTH  = {(2**N_IN){1'b0}},
   parameter int                   CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic             dut_y,
   output logic [N_IN-1:0]  vec_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             mismatch,
   output logic [N_IN-1:0]  mismatch_vec,
   output logic [CNT_W-1:0] error_count,
   output logic [CNT_W-1:0] test_count
);

   // Settle counter only needs to reach SETTLE-2; pass counter must hold REPEAT.
   localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int PC_W = $clog2(REPEAT + 1);
   localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'((SETTLE > 1) ? (SETTLE - 2) : 0);
   localparam logic [PC_W-1:0] REPEAT_LAST = PC_W'(REPEAT - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // With a one-cycle hold there is nothing to settle: go straight to CHECK.
   localparam state_t FIRST_ST = (SETTLE == 1) ? ST_CHECK : ST_SETTLE;

   state_t           state_q, state_d;
   logic [N_IN-1:0]  vec_q, vec_d;
   logic [SC_W-1:0]  sc_q, sc_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             mism_q, mism_d;
   logic [N_IN-1:0]  mvec_q, mvec_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [CNT_W-1:0] tst_q, tst_d;

   // Next-state and next-output computation for the run sequencer.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      sc_d    = sc_q;
      pc_d    = pc_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      mism_d  = 1'b0;
      mvec_d  = mvec_q;
      err_d   = err_q;
      tst_d   = tst_q;
      case (state_q)
         ST_IDLE: begin
            // abort beats start; results hold until a run actually starts
            if (start && !abort) begin
               state_d = FIRST_ST;
               vec_d   = {N_IN{1'b0}};
               sc_d    = {SC_W{1'b0}};
               pc_d    = {PC_W{1'b0}};
               busy_d  = 1'b1;
               mvec_d  = {N_IN{1'b0}};
               err_d   = {CNT_W{1'b0}};
               tst_d   = {CNT_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               pass_d  = 1'b0;
            end else if (sc_q == SETTLE_LAST) begin
               state_d = ST_CHECK;
               sc_d    = {SC_W{1'b0}};
            end else begin
               sc_d    = sc_q + SC_W'(1);
            end
         end
         ST_CHECK: begin
            if (abort) begin
               // the compare in this cycle is dropped
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               pass_d  = 1'b0;
            end else begin
               if (tst_q != {CNT_W{1'b1}}) begin
                  tst_d = tst_q + CNT_W'(1);
               end else begin
                  tst_d = tst_q;
               end
               if (dut_y != TRUTH[vec_q]) begin
                  mism_d = 1'b1;
                  mvec_d = vec_q;
                  if (err_q != {CNT_W{1'b1}}) begin
                     err_d = err_q + CNT_W'(1);
                  end else begin
                     err_d = err_q;
                  end
               end else begin
                  mism_d = 1'b0;
               end
               if (vec_q != {N_IN{1'b1}}) begin
                  vec_d   = vec_q + N_IN'(1);
                  state_d = FIRST_ST;
               end else begin
                  // end of a pass: wrap the vector and count the pass
                  vec_d = {N_IN{1'b0}};
                  pc_d  = pc_q + PC_W'(1);
                  if (pc_q == REPEAT_LAST) begin
                     state_d = ST_DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     pass_d  = (err_d == {CNT_W{1'b0}});
                  end else begin
                     state_d = FIRST_ST;
                  end
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         vec_q   <= {N_IN{1'b0}};
         sc_q    <= {SC_W{1'b0}};
         pc_q    <= {PC_W{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         mism_q  <= 1'b0;
         mvec_q  <= {N_IN{1'b0}};
         err_q   <= {CNT_W{1'b0}};
         tst_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         sc_q    <= sc_d;
         pc_q    <= pc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         mism_q  <= mism_d;
         mvec_q  <= mvec_d;
         err_q   <= err_d;
         tst_q   <= tst_d;
      end
   end

   assign vec_out      = vec_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign mismatch     = mism_q;
   assign mismatch_vec = mvec_q;
   assign error_count  = err_q;
   assign test_count   = tst_q;

endmodule

// File: tb/tb_exhaustive_vec_checker.sv
// Self-checking bench for exhaustive_vec_checker: three instances (defaults,
// a 2-input single-cycle variant, a 4-bit-counter variant) driven by directed
// and random runs, checked against arithmetic expectations of a run.
module tb_exhaustive_vec_checker;

   localparam logic [15:0] TRUTH_A = 16'hA5C3;
   localparam logic [3:0]  TRUTH_B = 4'b0110;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n = 1'b0;
   logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
   logic [15:0] mask_a = 16'h0000;
   logic dut_y_a, dut_y_b, dut_y_c;

   logic [3:0]  vec_a, mvec_a;
   logic        busy_a, done_a, pass_a, mism_a;
   logic [15:0] err_a, tst_a;
   logic [1:0]  vec_b, mvec_b;
   logic        busy_b, done_b, pass_b, mism_b;
   logic [15:0] err_b, tst_b;
   logic [3:0]  vec_c, mvec_c;
   logic        busy_c, done_c, pass_c, mism_c;
   logic [3:0]  err_c, tst_c;

   int n_checks = 0;
   int n_errors = 0;

   // reference DUTs: truth table with selected vectors inverted (A), exact (B), always wrong (C)
   assign dut_y_a = TRUTH_A[vec_a] ^ mask_a[vec_a];
   assign dut_y_b = TRUTH_B[vec_b];
   assign dut_y_c = 1'b1;

   exhaustive_vec_checker #(.N_IN(4), .SETTLE(5), .REPEAT(2), .TRUTH(TRUTH_A), .CNT_W(16)) u_a (
      .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort_a), .dut_y(dut_y_a),
      .vec_out(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a), .mismatch(mism_a),
      .mismatch_vec(mvec_a), .error_count(err_a), .test_count(tst_a));

   exhaustive_vec_checker #(.N_IN(2), .SETTLE(1), .REPEAT(1), .TRUTH(TRUTH_B), .CNT_W(16)) u_b (
      .clk(clk), .reset_n(reset_n), .start(start_b), .abort(1'b0), .dut_y(dut_y_b),
      .vec_out(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b), .mismatch(mism_b),
      .mismatch_vec(mvec_b), .error_count(err_b), .test_count(tst_b));

   exhaustive_vec_checker #(.N_IN(4), .SETTLE(5), .REPEAT(2), .TRUTH(16'h0000), .CNT_W(4)) u_c (
      .clk(clk), .reset_n(reset_n), .start(start_c), .abort(1'b0), .dut_y(dut_y_c),
      .vec_out(vec_c), .busy(busy_c), .done(done_c), .pass(pass_c), .mismatch(mism_c),
      .mismatch_vec(mvec_c), .error_count(err_c), .test_count(tst_c));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Full run on instance A; mask marks vectors where the DUT answers wrongly.
   // start_at > 0 pulses start at that busy cycle, which must be ignored.
   task automatic run_a(input string tag, input logic [15:0] mask, input int start_at);
      int cyc, bad_vec, n_mism, n_done, pop, hi;
      pop = 0;
      hi  = 0;
      for (int v = 0; v < 16; v++) begin
         if (mask[v]) begin
            pop++;
            hi = v;
         end
      end
      mask_a = mask;
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      cyc = 0; bad_vec = 0; n_mism = 0; n_done = 0;
      while (busy_a && cyc < 400) begin
         if ({28'd0, vec_a} !== 32'((cyc / 5) % 16)) bad_vec++;
         if (mism_a) n_mism++;
         if (done_a) n_done++;
         cyc++;
         start_a = (cyc == start_at) ? 1'b1 : 1'b0;
         @(negedge clk);
      end
      start_a = 1'b0;
      if (mism_a) n_mism++;
      check_val({tag, "_busy_cycles"}, 32'(cyc), 32'd160);
      check_val({tag, "_vec_seq_bad"}, 32'(bad_vec), 32'd0);
      check_val({tag, "_done"}, {31'd0, done_a}, 32'd1);
      check_val({tag, "_pass"}, {31'd0, pass_a}, (pop == 0) ? 32'd1 : 32'd0);
      check_val({tag, "_err"}, {16'd0, err_a}, 32'(2 * pop));
      check_val({tag, "_tst"}, {16'd0, tst_a}, 32'd32);
      check_val({tag, "_mvec"}, {28'd0, mvec_a}, 32'(hi));
      @(negedge clk);
      check_val({tag, "_done_width"}, {31'd0, done_a}, 32'd0);
      check_val({tag, "_done_in_busy"}, 32'(n_done), 32'd0);
      check_val({tag, "_mism_pulses"}, 32'(n_mism), 32'(2 * pop));
   endtask

   // Start a run on A and abort it while in busy cycle k (0 = first busy cycle).
   task automatic abort_a_at(input string tag, input int k);
      mask_a = 16'h0000;
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      for (int c = 0; c < k; c++) @(negedge clk);
      abort_a = 1'b1;
      @(negedge clk); abort_a = 1'b0;
      check_val({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
      check_val({tag, "_done"}, {31'd0, done_a}, 32'd0);
      check_val({tag, "_pass"}, {31'd0, pass_a}, 32'd0);
      check_val({tag, "_tst"}, {16'd0, tst_a}, 32'(k / 5));
      check_val({tag, "_vec"}, {28'd0, vec_a}, 32'((k / 5) % 16));
   endtask

   initial begin
      int cyc, n_mism;
      repeat (3) @(negedge clk);
      check_val("rst_vec", {28'd0, vec_a}, 32'd0);
      check_val("rst_busy", {31'd0, busy_a}, 32'd0);
      check_val("rst_pass", {31'd0, pass_a}, 32'd0);
      check_val("rst_err", {16'd0, err_a}, 32'd0);
      check_val("rst_tst", {16'd0, tst_a}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      run_a("match", 16'h0000, 0);
      run_a("stuck0", TRUTH_A, 0);

      // 2-input, single-cycle hold: one vector per cycle, done in cycle 5
      @(negedge clk); start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
      n_mism = 0;
      for (int c = 1; c <= 4; c++) begin
         check_val("b_vec", {30'd0, vec_b}, 32'(c - 1));
         check_val("b_busy", {31'd0, busy_b}, 32'd1);
         if (mism_b) n_mism++;
         @(negedge clk);
      end
      if (mism_b) n_mism++;
      check_val("b_done_c5", {31'd0, done_b}, 32'd1);
      check_val("b_pass", {31'd0, pass_b}, 32'd1);
      check_val("b_tst", {16'd0, tst_b}, 32'd4);
      check_val("b_err", {16'd0, err_b}, 32'd0);
      check_val("b_mvec", {30'd0, mvec_b}, 32'd0);
      check_val("b_mism", 32'(n_mism), 32'd0);

      // abort once seven compares are done, then verify the hold in IDLE
      abort_a_at("abort7", 35);
      repeat (4) @(negedge clk);
      check_val("abort7_tst_hold", {16'd0, tst_a}, 32'd7);
      check_val("abort7_vec_hold", {28'd0, vec_a}, 32'd7);
      run_a("restart_start_busy", 16'h0000, 50);

      for (int i = 0; i < 5; i++) run_a("rand_run", 16'($urandom) & 16'($urandom), 0);
      for (int i = 0; i < 4; i++) abort_a_at("rand_abort", $urandom_range(1, 159));

      // saturating 4-bit counters with an always-wrong DUT
      @(negedge clk); start_c = 1'b1;
      @(negedge clk); start_c = 1'b0;
      cyc = 0; n_mism = 0;
      while (busy_c && cyc < 400) begin
         if (mism_c) n_mism++;
         cyc++;
         @(negedge clk);
      end
      if (mism_c) n_mism++;
      check_val("c_busy_cycles", 32'(cyc), 32'd160);
      check_val("c_done", {31'd0, done_c}, 32'd1);
      check_val("c_err_sat", {28'd0, err_c}, 32'd15);
      check_val("c_tst_sat", {28'd0, tst_c}, 32'd15);
      check_val("c_pass", {31'd0, pass_c}, 32'd0);
      check_val("c_mvec", {28'd0, mvec_c}, 32'd15);
      check_val("c_vec", {28'd0, vec_c}, 32'd0);
      check_val("c_mism", 32'(n_mism), 32'd32);

      // reset in the middle of a failing run, with start and abort also high
      mask_a = TRUTH_A;
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      repeat (60) @(negedge clk);
      reset_n = 1'b0; start_a = 1'b1; abort_a = 1'b1;
      @(negedge clk);
      check_val("mid_rst_vec", {28'd0, vec_a}, 32'd0);
      check_val("mid_rst_busy", {31'd0, busy_a}, 32'd0);
      check_val("mid_rst_done", {31'd0, done_a}, 32'd0);
      check_val("mid_rst_pass", {31'd0, pass_a}, 32'd0);
      check_val("mid_rst_mism", {31'd0, mism_a}, 32'd0);
      check_val("mid_rst_mvec", {28'd0, mvec_a}, 32'd0);
      check_val("mid_rst_err", {16'd0, err_a}, 32'd0);
      check_val("mid_rst_tst", {16'd0, tst_a}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check_val("start_abort_idle", {31'd0, busy_a}, 32'd0);
      start_a = 1'b0; abort_a = 1'b0;
      @(negedge clk);
      check_val("post_rst_idle", {31'd0, busy_a}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
